// File: rtl/branch_scheduler_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : branch_scheduler_if
// Description : Dispatch, CDB wakeup and issue-register signals of the branch
//               reservation station.
// Revision    : 1.0
//------------------------------------------------------------------------------
interface branch_scheduler_if #(
   parameter int WIDTH   = 31,
   parameter int C_WIDTH = 7,
   parameter int T_WIDTH = 3,
   parameter int DEPTH   = 4
);
   logic                       dispatchValid;
   logic                       dispatchReady;
   logic [WIDTH:0]             dSrc1, dSrc2;
   logic                       dRdy1, dRdy2;
   logic [T_WIDTH:0]           dTag1, dTag2;
   logic [WIDTH:0]             dPC, dImm, dPredPC;
   logic [C_WIDTH:0]           dControl;
   logic [T_WIDTH:0]           dRobTag;
   logic                       cdbValid;
   logic [T_WIDTH:0]           cdbTag;
   logic [WIDTH:0]             cdbData;
   logic                       issueValid;
   logic [WIDTH:0]             iSrc1, iSrc2, iPC, iImm, iPredPC;
   logic [C_WIDTH:0]           iControl;
   logic [T_WIDTH:0]           iRobTag;
   logic                       cdbGrant;
   logic                       flush;
   logic [$clog2(DEPTH+1)-1:0] occupancy;

   modport master (
      output dispatchValid, dSrc1, dSrc2, dRdy1, dRdy2, dTag1, dTag2,
             dPC, dImm, dPredPC, dControl, dRobTag,
             cdbValid, cdbTag, cdbData, cdbGrant, flush,
      input  dispatchReady, issueValid, iSrc1, iSrc2, iPC, iImm, iPredPC,
             iControl, iRobTag, occupancy
   );

   modport slave (
      input  dispatchValid, dSrc1, dSrc2, dRdy1, dRdy2, dTag1, dTag2,
             dPC, dImm, dPredPC, dControl, dRobTag,
             cdbValid, cdbTag, cdbData, cdbGrant, flush,
      output dispatchReady, issueValid, iSrc1, iSrc2, iPC, iImm, iPredPC,
             iControl, iRobTag, occupancy
   );
endinterface
`default_nettype wire

// File: rtl/branch_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : branch_scheduler
// Description : Collapsing-queue reservation station for the branch unit with
//               oldest-ready select into a grant-held issue register.
//               Option macro: BRANCH_SCHED_WAKEUP_BYPASS_EN (same-cycle wakeup).
// Revision    : 1.0
//------------------------------------------------------------------------------
module branch_scheduler #(
   parameter int WIDTH   = 31,
   parameter int C_WIDTH = 7,
   parameter int T_WIDTH = 3,
   parameter int DEPTH   = 4
) (
   input  wire logic         clk,
   input  wire logic         reset,
   branch_scheduler_if.slave bus
);
   localparam int c_OCC_W = $clog2(DEPTH + 1);
   localparam int c_IDX_W = $clog2(DEPTH);

   typedef struct packed {
      logic             rdy1;
      logic             rdy2;
      logic [T_WIDTH:0] tag1;
      logic [T_WIDTH:0] tag2;
      logic [WIDTH:0]   src1;
      logic [WIDTH:0]   src2;
      logic [WIDTH:0]   pc;
      logic [WIDTH:0]   imm;
      logic [WIDTH:0]   pred;
      logic [C_WIDTH:0] ctl;
      logic [T_WIDTH:0] rob;
   } slot_t;

   logic [DEPTH-1:0]   r_valid;
   slot_t              r_slot [DEPTH];
   logic [c_OCC_W-1:0] r_occ;
   logic               r_iv;
   logic [WIDTH:0]     r_isrc1, r_isrc2, r_ipc, r_iimm, r_ipred;
   logic [C_WIDTH:0]   r_ictl;
   logic [T_WIDTH:0]   r_irob;

   slot_t              w_woke [DEPTH+1];
   logic [DEPTH:0]     w_valid_ext;
   slot_t              w_draw, w_disp;
   logic [DEPTH-1:0]   w_rdy;
   logic [WIDTH:0]     w_csrc1 [DEPTH];
   logic [WIDTH:0]     w_csrc2 [DEPTH];
   logic               w_found;
   logic [c_IDX_W-1:0] w_sel;
   logic               w_dready, w_sel_en, w_accept, w_direct, w_shift, w_push;
   logic [c_OCC_W-1:0] w_wr_idx;
   logic [DEPTH-1:0]   w_nvalid;
   slot_t              w_nslot [DEPTH];

   function automatic slot_t f_wake(slot_t s, logic v, logic [T_WIDTH:0] t,
                                    logic [WIDTH:0] d);
      slot_t o;
      o = s;
      if (v && !o.rdy1 && o.tag1 == t) begin
         o.rdy1 = 1'b1;
         o.src1 = d;
      end
      if (v && !o.rdy2 && o.tag2 == t) begin
         o.rdy2 = 1'b1;
         o.src2 = d;
      end
      return o;
   endfunction

   always_comb begin
      w_draw = '{rdy1: bus.dRdy1, rdy2: bus.dRdy2, tag1: bus.dTag1, tag2: bus.dTag2,
                 src1: bus.dSrc1, src2: bus.dSrc2, pc: bus.dPC, imm: bus.dImm,
                 pred: bus.dPredPC, ctl: bus.dControl, rob: bus.dRobTag};
      w_disp = f_wake(w_draw, bus.cdbValid, bus.cdbTag, bus.cdbData);
      w_woke[DEPTH] = '0;
      w_valid_ext   = {1'b0, r_valid};
      for (int i = 0; i < DEPTH; i++) begin
         w_woke[i] = f_wake(r_slot[i], bus.cdbValid & r_valid[i], bus.cdbTag, bus.cdbData);
`ifdef BRANCH_SCHED_WAKEUP_BYPASS_EN
         w_rdy[i]   = r_valid[i] & w_woke[i].rdy1 & w_woke[i].rdy2;
         w_csrc1[i] = w_woke[i].src1;
         w_csrc2[i] = w_woke[i].src2;
`else
         w_rdy[i]   = r_valid[i] & r_slot[i].rdy1 & r_slot[i].rdy2;
         w_csrc1[i] = r_slot[i].src1;
         w_csrc2[i] = r_slot[i].src2;
`endif
      end
      // Scan downward so the oldest ready slot wins.
      w_found = 1'b0;
      w_sel   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (w_rdy[i]) begin
            w_found = 1'b1;
            w_sel   = c_IDX_W'(i);
         end
      end
   end

   // A dispatch that arrives fully ready with nothing older ready goes straight
   // to the issue register; operands woken on the dispatch cycle do not.
   assign w_dready = (r_occ < c_OCC_W'(DEPTH));
   assign w_sel_en = ~r_iv | bus.cdbGrant;
   assign w_accept = bus.dispatchValid & w_dready & ~bus.flush;
   assign w_direct = w_sel_en & ~w_found & w_accept & bus.dRdy1 & bus.dRdy2;
   assign w_shift  = w_sel_en & w_found;
   assign w_push   = w_accept & ~w_direct;
   assign w_wr_idx = r_occ - c_OCC_W'(w_shift);

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         if (w_shift && c_IDX_W'(i) >= w_sel) begin
            w_nvalid[i] = w_valid_ext[i+1];
            w_nslot[i]  = w_woke[i+1];
         end else begin
            w_nvalid[i] = w_valid_ext[i];
            w_nslot[i]  = w_woke[i];
         end
         if (w_push && w_wr_idx == c_OCC_W'(i)) begin
            w_nvalid[i] = 1'b1;
            w_nslot[i]  = w_disp;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= '0;
         r_occ   <= '0;
         for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
      end else if (bus.flush) begin
         r_valid <= '0;
         r_occ   <= '0;
      end else begin
         r_valid <= w_nvalid;
         r_occ   <= r_occ + c_OCC_W'(w_push) - c_OCC_W'(w_shift);
         for (int i = 0; i < DEPTH; i++) r_slot[i] <= w_nslot[i];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset || bus.flush) begin
         r_iv    <= 1'b0;
         r_isrc1 <= '0; r_isrc2 <= '0; r_ipc <= '0; r_iimm <= '0; r_ipred <= '0;
         r_ictl  <= '0; r_irob  <= '0;
      end else if (w_sel_en) begin
         if (w_found) begin
            r_iv    <= 1'b1;
            r_isrc1 <= w_csrc1[w_sel];
            r_isrc2 <= w_csrc2[w_sel];
            r_ipc   <= r_slot[w_sel].pc;
            r_iimm  <= r_slot[w_sel].imm;
            r_ipred <= r_slot[w_sel].pred;
            r_ictl  <= r_slot[w_sel].ctl;
            r_irob  <= r_slot[w_sel].rob;
         end else if (w_direct) begin
            r_iv    <= 1'b1;
            r_isrc1 <= w_disp.src1;
            r_isrc2 <= w_disp.src2;
            r_ipc   <= w_disp.pc;
            r_iimm  <= w_disp.imm;
            r_ipred <= w_disp.pred;
            r_ictl  <= w_disp.ctl;
            r_irob  <= w_disp.rob;
         end else begin
            r_iv    <= 1'b0;
            r_isrc1 <= '0; r_isrc2 <= '0; r_ipc <= '0; r_iimm <= '0; r_ipred <= '0;
            r_ictl  <= '0; r_irob  <= '0;
         end
      end
   end

   assign bus.dispatchReady = w_dready;
   assign bus.occupancy     = r_occ;
   assign bus.issueValid    = r_iv;
   assign bus.iSrc1         = r_isrc1;
   assign bus.iSrc2         = r_isrc2;
   assign bus.iPC           = r_ipc;
   assign bus.iImm          = r_iimm;
   assign bus.iPredPC       = r_ipred;
   assign bus.iControl      = r_ictl;
   assign bus.iRobTag       = r_irob;
endmodule
`default_nettype wire

// File: tb/tb_branch_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_branch_scheduler
// Description : Self-checking bench for branch_scheduler: vector table, corner
//               sequences and random traffic against a queue-based model.
// Revision    : 1.0
//------------------------------------------------------------------------------
module tb_branch_scheduler;
   localparam int WIDTH = 31, C_WIDTH = 7, T_WIDTH = 3, DEPTH = 4;
`ifdef BRANCH_SCHED_WAKEUP_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   branch_scheduler_if #(.WIDTH(WIDTH), .C_WIDTH(C_WIDTH), .T_WIDTH(T_WIDTH), .DEPTH(DEPTH)) bus ();
   branch_scheduler #(.WIDTH(WIDTH), .C_WIDTH(C_WIDTH), .T_WIDTH(T_WIDTH), .DEPTH(DEPTH))
      dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct packed {
      logic rdy1, rdy2;
      logic [T_WIDTH:0] tag1, tag2;
      logic [WIDTH:0] src1, src2, pc, imm, pred;
      logic [C_WIDTH:0] ctl;
      logic [T_WIDTH:0] rob;
   } ent_t;

   ent_t q[$];
   bit   m_iv;
   ent_t m_ie;
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic ent_t wake(ent_t e);
      ent_t o = e;
      if (bus.cdbValid) begin
         if (!o.rdy1 && o.tag1 == bus.cdbTag) begin o.rdy1 = 1'b1; o.src1 = bus.cdbData; end
         if (!o.rdy2 && o.tag2 == bus.cdbTag) begin o.rdy2 = 1'b1; o.src2 = bus.cdbData; end
      end
      return o;
   endfunction

   // Behavioural model: oldest-first list; the new dispatch is the youngest candidate.
   task automatic model_step();
      ent_t d;
      bit   acc, sel_en, direct_ok;
      int   f;
      if (bus.flush) begin
         q.delete(); m_iv = 0; m_ie = '0;
         return;
      end
      acc    = bus.dispatchValid && (q.size() < DEPTH);
      sel_en = !m_iv || bus.cdbGrant;
      d = '{rdy1: bus.dRdy1, rdy2: bus.dRdy2, tag1: bus.dTag1, tag2: bus.dTag2,
            src1: bus.dSrc1, src2: bus.dSrc2, pc: bus.dPC, imm: bus.dImm,
            pred: bus.dPredPC, ctl: bus.dControl, rob: bus.dRobTag};
      direct_ok = d.rdy1 && d.rdy2;
      d = wake(d);
      if (BYP) foreach (q[i]) q[i] = wake(q[i]);
      f = -1;
      foreach (q[i]) if (f < 0 && q[i].rdy1 && q[i].rdy2) f = i;
      if (!BYP) foreach (q[i]) q[i] = wake(q[i]);
      if (sel_en) begin
         if (f >= 0) begin
            m_iv = 1; m_ie = q[f]; q.delete(f);
         end else if (acc && direct_ok) begin
            m_iv = 1; m_ie = d; acc = 0;
         end else begin
            m_iv = 0; m_ie = '0;
         end
      end
      if (acc) q.push_back(d);
   endtask

   task automatic compare();
      chk("issueValid", bus.issueValid, m_iv);
      chk("occupancy", 64'(bus.occupancy), 64'(q.size()));
      chk("dispatchReady", bus.dispatchReady, q.size() < DEPTH);
      if (m_iv) begin
         chk("iSrc1", bus.iSrc1, m_ie.src1);
         chk("iSrc2", bus.iSrc2, m_ie.src2);
         chk("iPC", bus.iPC, m_ie.pc);
         chk("iImm", bus.iImm, m_ie.imm);
         chk("iPredPC", bus.iPredPC, m_ie.pred);
         chk("iControl", bus.iControl, m_ie.ctl);
         chk("iRobTag", bus.iRobTag, m_ie.rob);
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic idle();
      bus.dispatchValid = 0; bus.dSrc1 = '0; bus.dSrc2 = '0; bus.dRdy1 = 0; bus.dRdy2 = 0;
      bus.dTag1 = '0; bus.dTag2 = '0; bus.dPC = '0; bus.dImm = '0; bus.dPredPC = '0;
      bus.dControl = '0; bus.dRobTag = '0; bus.cdbValid = 0; bus.cdbTag = '0;
      bus.cdbData = '0; bus.cdbGrant = 0; bus.flush = 0;
   endtask

   task automatic disp(input bit r1, input bit r2, input logic [3:0] t1, input logic [3:0] t2,
                       input logic [31:0] s1, input logic [31:0] s2, input logic [3:0] rob);
      bus.dispatchValid = 1; bus.dRdy1 = r1; bus.dRdy2 = r2; bus.dTag1 = t1; bus.dTag2 = t2;
      bus.dSrc1 = s1; bus.dSrc2 = s2; bus.dRobTag = rob;
      bus.dPC = 32'h1000 | 32'(rob); bus.dImm = 32'h20 | 32'(rob);
      bus.dPredPC = 32'h8000 | 32'(rob); bus.dControl = {4'h0, rob};
   endtask

   task automatic cdb(input logic [3:0] t, input logic [31:0] d);
      bus.cdbValid = 1; bus.cdbTag = t; bus.cdbData = d;
   endtask

   typedef struct {
      bit dv, r1, r2; logic [3:0] t1; logic [31:0] s1, s2; logic [3:0] rob;
      bit cv; logic [3:0] ct; logic [31:0] cd; bit g;
      bit e_iv; logic [31:0] e_s1; logic [3:0] e_rob; int e_occ;
   } vec_t;

   vec_t vecs[7];

   initial begin
      vecs[0] = '{1,1,1,4'd0,32'd5,32'd5,4'd1, 0,4'd0,32'd0, 1, 1,32'd5,4'd1,0};
      vecs[1] = '{0,0,0,4'd0,32'd0,32'd0,4'd0, 0,4'd0,32'd0, 1, 0,32'd0,4'd0,0};
      vecs[2] = '{1,0,1,4'd3,32'd0,32'd7,4'd2, 0,4'd0,32'd0, 1, 0,32'd0,4'd0,1};
      vecs[3] = '{1,1,1,4'd0,32'd9,32'd1,4'd3, 0,4'd0,32'd0, 1, 1,32'd9,4'd3,1};
      vecs[4] = '{0,0,0,4'd0,32'd0,32'd0,4'd0, 1,4'd3,32'h10, 0, 1,32'd9,4'd3,1};
      vecs[5] = '{0,0,0,4'd0,32'd0,32'd0,4'd0, 0,4'd0,32'd0, 1, 1,32'h10,4'd2,0};
      vecs[6] = '{0,0,0,4'd0,32'd0,32'd0,4'd0, 0,4'd0,32'd0, 1, 0,32'd0,4'd0,0};

      idle();
      reset = 0;
      m_iv = 0; m_ie = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.issueValid", bus.issueValid, 0);
      chk("rst.occupancy", 64'(bus.occupancy), 0);
      chk("rst.dispatchReady", bus.dispatchReady, 1);
      chk("rst.iSrc1", bus.iSrc1, 0);
      chk("rst.iPC", bus.iPC, 0);
      chk("rst.iRobTag", bus.iRobTag, 0);
      reset = 1;

      for (int k = 0; k < 7; k++) begin
         idle();
         if (vecs[k].dv) disp(vecs[k].r1, vecs[k].r2, vecs[k].t1, 4'd0, vecs[k].s1, vecs[k].s2, vecs[k].rob);
         if (vecs[k].cv) cdb(vecs[k].ct, vecs[k].cd);
         bus.cdbGrant = vecs[k].g;
         cycle();
         chk($sformatf("vec%0d.iv", k), bus.issueValid, vecs[k].e_iv);
         chk($sformatf("vec%0d.occ", k), 64'(bus.occupancy), 64'(vecs[k].e_occ));
         if (vecs[k].e_iv) begin
            chk($sformatf("vec%0d.iSrc1", k), bus.iSrc1, vecs[k].e_s1);
            chk($sformatf("vec%0d.rob", k), bus.iRobTag, vecs[k].e_rob);
         end
      end

      // Fill the station with unready entries, then wake only slot 2.
      for (int k = 0; k < 4; k++) begin
         idle(); disp(0, 1, 4'(4 + k), 4'd15, 32'd0, 32'(k), 4'(k)); cycle();
      end
      chk("full.occ", 64'(bus.occupancy), 4);
      chk("full.dispatchReady", bus.dispatchReady, 0);
      idle(); disp(1, 1, 4'd0, 4'd0, 32'd1, 32'd1, 4'd12); cdb(4'd6, 32'hAB); cycle();
      chk("wake.dispatchReady", bus.dispatchReady, BYP);
      idle(); cycle();
      chk("wake.iv", bus.issueValid, 1);
      chk("wake.rob", bus.iRobTag, 2);
      chk("wake.iSrc1", bus.iSrc1, 32'hAB);
      chk("wake.occ", 64'(bus.occupancy), 3);
      chk("wake.dispatchReady", bus.dispatchReady, 1);

      // Hold without grant, then grant loads the next ready entry.
      for (int k = 0; k < 3; k++) begin
         idle(); if (k == 0) cdb(4'd4, 32'h44); cycle();
         chk("hold.rob", bus.iRobTag, 2);
         chk("hold.iSrc1", bus.iSrc1, 32'hAB);
         chk("hold.iPC", bus.iPC, 32'h1002);
      end
      idle(); bus.cdbGrant = 1; cycle();
      chk("grant.rob", bus.iRobTag, 0);
      chk("grant.iSrc1", bus.iSrc1, 32'h44);
      chk("grant.occ", 64'(bus.occupancy), 2);

      // Flush with three entries, busy issue register and a same-cycle dispatch.
      idle(); disp(0, 1, 4'd9, 4'd15, 32'd0, 32'd0, 4'd7); cycle();
      chk("preflush.occ", 64'(bus.occupancy), 3);
      idle(); disp(1, 1, 4'd0, 4'd0, 32'd3, 32'd3, 4'd8); bus.cdbGrant = 1; bus.flush = 1; cycle();
      chk("flush.iv", bus.issueValid, 0);
      chk("flush.occ", 64'(bus.occupancy), 0);
      idle(); bus.cdbGrant = 1; cycle();
      chk("postflush.iv", bus.issueValid, 0);
      chk("postflush.occ", 64'(bus.occupancy), 0);

      // Last operand woken by CDB with the issue register empty.
      idle(); disp(0, 1, 4'd10, 4'd15, 32'd0, 32'd3, 4'd9); cycle();
      idle(); cdb(4'd10, 32'h77); cycle();
      chk("byp.iv_n1", bus.issueValid, BYP);
      idle(); cycle();
      chk("byp.iv_n2", bus.issueValid, 1);
      chk("byp.iSrc1", bus.iSrc1, 32'h77);
      chk("byp.rob", bus.iRobTag, 9);
      idle(); bus.cdbGrant = 1; cycle();

      // Random traffic against the model.
      for (int n = 0; n < 800; n++) begin
         idle();
         if ($urandom_range(1)) begin
            disp($urandom_range(9) < 6, $urandom_range(9) < 6, 4'($urandom), 4'($urandom),
                 $urandom, $urandom, 4'($urandom));
            bus.dPC = $urandom; bus.dImm = $urandom; bus.dPredPC = $urandom;
            bus.dControl = 8'($urandom);
         end
         if ($urandom_range(9) < 4) cdb(4'($urandom), $urandom);
         bus.cdbGrant = ($urandom_range(9) < 6);
         bus.flush    = ($urandom_range(99) < 3);
         cycle();
      end

      // Asynchronous reset between clock edges.
      idle(); disp(1, 1, 4'd0, 4'd0, 32'd2, 32'd2, 4'd5); cycle();
      #2 reset = 0;
      #1;
      q.delete(); m_iv = 0; m_ie = '0;
      chk("async.iv", bus.issueValid, 0);
      chk("async.occ", 64'(bus.occupancy), 0);
      chk("async.iRobTag", bus.iRobTag, 0);
      @(posedge clk); #1 reset = 1;
      idle(); cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/branch_scheduler.md
# branch_scheduler

Reservation-station scheduler for the branch functional unit. It holds up to DEPTH dispatched branch/JAL/JALR instructions, captures missing source operands from the common data bus (CDB), and selects the oldest ready entry into a single issue register. The issue register drives the combinational branch ALU directly and is held until the CDB round-robin arbiter grants the ALU's write. It sits between dispatch/rename and the branch ALU; commit-stage flush clears it.

## Interface
- WIDTH, 31: data/PC MSB index (datapath is WIDTH+1 bits)
- C_WIDTH, 7: branchControl MSB index ({isJAL,isJALR,funct3,state[1:0],redirect})
- T_WIDTH, 3: ROB tag MSB index
- DEPTH, 4: entry count (2..8)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- dispatchValid  in  1  dispatch offers an instruction
- dispatchReady  out  1  occupancy < DEPTH
- dSrc1, dSrc2  in  WIDTH+1  operand values (meaningful when matching ready bit set)
- dRdy1, dRdy2  in  1  operand already available
- dTag1, dTag2  in  T_WIDTH+1  producer ROB tag of operand when not ready
- dPC, dImm, dPredPC  in  WIDTH+1  PC, extended immediate, predicted PC
- dControl  in  C_WIDTH+1  branchControl
- dRobTag  in  T_WIDTH+1  ROB tag of this instruction
- cdbValid  in  1  CDB broadcast valid
- cdbTag  in  T_WIDTH+1  broadcast tag
- cdbData  in  WIDTH+1  broadcast value
- issueValid  out  1  issue register occupied (branch ALU input valid)
- iSrc1, iSrc2, iPC, iImm, iPredPC  out  WIDTH+1  issue register fields
- iControl  out  C_WIDTH+1  issue register branchControl
- iRobTag  out  T_WIDTH+1  issue register ROB tag
- cdbGrant  in  1  arbiter granted the branch ALU's request this cycle
- flush  in  1  synchronous pipeline flush
- occupancy  out  $clog2(DEPTH+1)  valid station entries (excludes issue register)

## Operation
- Station is a collapsing queue: slot 0 oldest, valid slots contiguous from 0. Each slot: valid, rdy1/2, tag1/2, src1/2, PC, imm, predPC, control, robTag.
- Dispatch: accepted when dispatchValid & dispatchReady & !flush; written to slot (occupancy − shifted), i.e. tail after any same-cycle collapse.
- Wakeup: for every valid slot and for the incoming dispatch, each not-ready operand with tag == cdbTag while cdbValid captures cdbData and sets rdy. Both operands may wake in one cycle.
- Entry ready = valid & rdy1 & rdy2. JAL entries are dispatched with both rdy set by dispatch.
- Select: when issue register is empty or cdbGrant is high, the lowest-index ready slot moves into the issue register; slots above it shift down by one. No ready slot → issue register becomes empty (if granted) or stays empty.
- Issue register holds contents unchanged while issueValid & !cdbGrant.
- cdbGrant with issueValid low is ignored.
- flush: next edge clears all valid bits, issue register, occupancy; dispatch and select that cycle are discarded. flush has priority over every other event.
- Occupancy next = occupancy + accepted dispatch − selected entry.

## Timing
- Reset: issueValid=0, all i* outputs=0, occupancy=0, dispatchReady=1, all slot valids=0.
- Dispatch-to-issue minimum latency: 1 cycle (dispatched with both ready in cycle N → issueValid in N+1).
- Wakeup-to-select: entry woken in cycle N is selectable in N+1 (default build).
- Back-to-back: grant in cycle N with another ready slot → new instruction in issue register at N+1; one branch per cycle sustained.
- Full: occupancy==DEPTH → dispatchReady=0 even if a select occurs that cycle (no same-cycle free-slot reuse).
- CDB broadcast on dispatch cycle with matching tag is captured; never lost.
- Reset asserted mid-operation clears state immediately, independent of clk.

## Configuration
- BRANCH_SCHED_WAKEUP_BYPASS_EN defined: CDB match is forwarded into the ready computation and operand mux of station slots, so an entry woken in cycle N can be selected in cycle N (its iSrc carries cdbData). Undefined: one-cycle wakeup-to-select as above. Dispatch-cycle wakeup never bypasses to select in either build.

## Test plan
- Reset then dispatch BEQ, dRdy1=dRdy2=1, src 5/5, cdbGrant held 1 → issueValid=1 one cycle later with iSrc1=iSrc2=5, then 0; occupancy returns 0.
- Dispatch A (tag1=3 not ready) then B (ready); cdbTag=3 data=0x10 two cycles later → B issues first, A issues next with iSrc1=0x10.
- Fill 4 entries with unready operands → dispatchReady=0; wake slot 2 only → slot 2 issues, slots 3→2 shift, occupancy=3, dispatchReady=1.
- Issue register occupied, cdbGrant=0 for 3 cycles → i* fields stable; grant → next ready entry loaded following cycle.
- flush with 3 entries, valid issue register and simultaneous dispatch → next cycle issueValid=0, occupancy=0, dispatched instruction absent.
- With BRANCH_SCHED_WAKEUP_BYPASS_EN, empty issue register, broadcast completes last operand in cycle N → issueValid=1 at N+1 carrying cdbData (default build: N+2).
